// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction fetch stage: FSM states, the nop
// encoding, opcode field position and instruction size.
package fetch_stage_pkg;

    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        HOLD    = 2'd1,
        DISCARD = 2'd2
    } fetch_state_e;

    localparam logic [31:0] NOP_INSTR   = 32'h0000_0000;
    localparam int          OPCODE_MSB  = 31;
    localparam int          OPCODE_LSB  = 26;
    localparam int          INSTR_BYTES = 4;

endpackage

// File: rtl/ifid_reg.sv
// IF/ID pipeline register: valid / instruction / pc+4 with load enable and a
// synchronous clear that turns the entry into a bubble (nop, pc+4 zeroed).
module ifid_reg
    import fetch_stage_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic              i_clear,
    input  logic              i_valid,
    input  logic [DATA_W-1:0] i_instr,
    input  logic [ADDR_W-1:0] i_pc_plus4,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_instr,
    output logic [ADDR_W-1:0] o_pc_plus4
);

    // Entry register; clear wins over load so a flush can never be overridden.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_valid    <= 1'b0;
            o_instr    <= DATA_W'(NOP_INSTR);
            o_pc_plus4 <= '0;
        end else if (i_clear) begin
            o_valid    <= 1'b0;
            o_instr    <= DATA_W'(NOP_INSTR);
            o_pc_plus4 <= '0;
        end else if (i_load) begin
            o_valid    <= i_valid;
            o_instr    <= i_instr;
            o_pc_plus4 <= i_pc_plus4;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, instruction-memory request, one-entry skid
// buffer for words returned while the pipeline is stalled, and branch
// redirection with discard of an in-flight read.
//
// state   | meaning
// --------+------------------------------------------------------------
// FETCH   | request at pc; accepted word goes to IF/ID or the skid
// HOLD    | skid holds one word, no request, wait for stall to drop
// DISCARD | branch arrived while a read was outstanding; finish that
//         | read on the old address, drop the word, then go to target
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ready,
    input  logic [DATA_W-1:0] imem_rdata,
    input  logic              stall,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    output logic              ifid_valid,
    output logic [DATA_W-1:0] ifid_instr,
    output logic [ADDR_W-1:0] ifid_pc_plus4,
    output logic [5:0]        ifid_opcode
);

    fetch_state_e      r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_saved_target;
    logic              r_skid_valid;
    logic [DATA_W-1:0] r_skid_instr;
    logic [ADDR_W-1:0] r_skid_pc4;

    fetch_state_e      w_state_nxt;
    logic [ADDR_W-1:0] w_pc_nxt;
    logic [ADDR_W-1:0] w_saved_nxt;
    logic              w_skid_valid_nxt;
    logic [DATA_W-1:0] w_skid_instr_nxt;
    logic [ADDR_W-1:0] w_skid_pc4_nxt;
    logic              w_req;
    logic              w_ifid_load;
    logic              w_ifid_clear;
    logic              w_ifid_d_valid;
    logic [DATA_W-1:0] w_ifid_d_instr;
    logic [ADDR_W-1:0] w_ifid_d_pc4;
    logic [ADDR_W-1:0] w_pc_plus4;
    logic [ADDR_W-1:0] w_target;

    // Sequential PC increment wraps naturally at 2^ADDR_W.
    assign w_pc_plus4 = r_pc + ADDR_W'(INSTR_BYTES);
    // Branch targets are forced onto a word boundary.
    assign w_target   = branch_target & ~{{(ADDR_W-2){1'b0}}, 2'b11};

    // A request must never be visible while reset is held.
    assign imem_req    = w_req & ~rst;
    assign imem_addr   = r_pc;
    assign ifid_opcode = ifid_instr[OPCODE_MSB:OPCODE_LSB];

    // State, PC, saved target and skid buffer registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= FETCH;
            r_pc           <= RESET_PC;
            r_saved_target <= RESET_PC;
            r_skid_valid   <= 1'b0;
            r_skid_instr   <= DATA_W'(NOP_INSTR);
            r_skid_pc4     <= '0;
        end else begin
            r_state        <= w_state_nxt;
            r_pc           <= w_pc_nxt;
            r_saved_target <= w_saved_nxt;
            r_skid_valid   <= w_skid_valid_nxt;
            r_skid_instr   <= w_skid_instr_nxt;
            r_skid_pc4     <= w_skid_pc4_nxt;
        end
    end

    // Next-state, PC selection and IF/ID control; branch outranks stall.
    always_comb begin
        w_state_nxt      = r_state;
        w_pc_nxt         = r_pc;
        w_saved_nxt      = r_saved_target;
        w_skid_valid_nxt = r_skid_valid;
        w_skid_instr_nxt = r_skid_instr;
        w_skid_pc4_nxt   = r_skid_pc4;
        w_req            = 1'b0;
        w_ifid_load      = 1'b0;
        w_ifid_clear     = 1'b0;
        w_ifid_d_valid   = 1'b0;
        w_ifid_d_instr   = DATA_W'(NOP_INSTR);
        w_ifid_d_pc4     = '0;

        case (r_state)
            FETCH: begin
                w_req = 1'b1;
                if (branch_taken) begin
                    w_ifid_clear     = 1'b1;
                    w_skid_valid_nxt = 1'b0;
                    if (imem_ready) begin
                        w_pc_nxt = w_target;
                    end else begin
                        // Read still in flight: keep the address stable until it completes.
                        w_saved_nxt = w_target;
                        w_state_nxt = DISCARD;
                    end
                end else if (imem_ready) begin
                    w_pc_nxt = w_pc_plus4;
                    if (stall) begin
                        w_skid_valid_nxt = 1'b1;
                        w_skid_instr_nxt = imem_rdata;
                        w_skid_pc4_nxt   = w_pc_plus4;
                        w_state_nxt      = HOLD;
                    end else begin
                        w_ifid_load    = 1'b1;
                        w_ifid_d_valid = 1'b1;
                        w_ifid_d_instr = imem_rdata;
                        w_ifid_d_pc4   = w_pc_plus4;
                    end
                end else if (!stall) begin
                    w_ifid_clear = 1'b1;
                end
            end

            HOLD: begin
                if (branch_taken) begin
                    w_ifid_clear     = 1'b1;
                    w_skid_valid_nxt = 1'b0;
                    w_pc_nxt         = w_target;
                    w_state_nxt      = FETCH;
                end else if (!stall) begin
                    w_ifid_load      = 1'b1;
                    w_ifid_d_valid   = r_skid_valid;
                    w_ifid_d_instr   = r_skid_instr;
                    w_ifid_d_pc4     = r_skid_pc4;
                    w_skid_valid_nxt = 1'b0;
                    w_state_nxt      = FETCH;
                end
            end

            DISCARD: begin
                w_req = 1'b1;
                if (branch_taken) begin
                    w_ifid_clear     = 1'b1;
                    w_skid_valid_nxt = 1'b0;
                    w_saved_nxt      = w_target;
                    if (imem_ready) begin
                        w_pc_nxt    = w_target;
                        w_state_nxt = FETCH;
                    end
                end else begin
                    if (!stall) begin
                        w_ifid_clear = 1'b1;
                    end
                    if (imem_ready) begin
                        w_pc_nxt    = r_saved_target;
                        w_state_nxt = FETCH;
                    end
                end
            end

            default: begin
                w_state_nxt = FETCH;
            end
        endcase
    end

    ifid_reg #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ifid_reg (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_ifid_load),
        .i_clear    (w_ifid_clear),
        .i_valid    (w_ifid_d_valid),
        .i_instr    (w_ifid_d_instr),
        .i_pc_plus4 (w_ifid_d_pc4),
        .o_valid    (ifid_valid),
        .o_instr    (ifid_instr),
        .o_pc_plus4 (ifid_pc_plus4)
    );

endmodule
